// File: rtl/jstk_move_decoder_if.sv
// Bundle between the joystick sampler, the move decoder and the game FSM.
// The master side drives samples and the ready, and the slave side (the decoder) returns moves and status.
interface jstk_move_decoder_if #(
    parameter int AXIS_W = 10
);
    logic              sample_valid;
    logic [AXIS_W-1:0] x_pos;
    logic [AXIS_W-1:0] y_pos;
    logic              btn;
    logic              move_valid;
    logic [1:0]        move_dir;
    logic              move_ready;
    logic [2:0]        dir_level;
    logic              btn_press;
    logic [7:0]        drop_cnt;

    modport master (
        output sample_valid, x_pos, y_pos, btn, move_ready,
        input  move_valid, move_dir, dir_level, btn_press, drop_cnt
    );

    modport slave (
        input  sample_valid, x_pos, y_pos, btn, move_ready,
        output move_valid, move_dir, dir_level, btn_press, drop_cnt
    );
endinterface

// File: rtl/jstk_move_decoder.sv
// Turns raw PmodJSTK samples into qualified, debounced 2048 move commands
// with a single-entry valid/ready buffer, optional auto-repeat and a button-press pulse.
module jstk_move_decoder #(
    parameter int AXIS_W     = 10,
    parameter int CENTER     = 512,
    parameter int DEADZONE   = 160,
    parameter int HYST       = 32,
    parameter int STABLE_CNT = 4,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_PER = 12_500_000
) (
    input  logic                  clk,
    input  logic                  rst,
    jstk_move_decoder_if.slave    bus
);

    localparam int QW   = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
    localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic signed [AXIS_W:0] CENTER_S = (AXIS_W+1)'(CENTER);
    localparam logic        [AXIS_W:0] DZ_LIM   = (AXIS_W+1)'(DEADZONE);
    localparam logic        [AXIS_W:0] REL_LIM  = (AXIS_W+1)'(DEADZONE - HYST);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cand_q, cand_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      held_q, held_d;
    logic [2:0]      dirLevel_q, dirLevel_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            rep_q, rep_d;
    logic            mvValid_q, mvValid_d;
    logic [1:0]      mvDir_q, mvDir_d;
    logic [7:0]      drop_q, drop_d;
    logic            btnPrev_q, btnPrev_d;
    logic            btnPress_q, btnPress_d;

    logic signed [AXIS_W:0] dx, dy;
    logic        [AXIS_W:0] absX, absY;
    logic                   isCentre;
    logic [1:0]             candDir;
    logic                   release_c;
    logic                   qualify;
    logic                   emit;
    logic [1:0]             emitDir;
    logic [QW-1:0]          qcntInc;
    logic [TW-1:0]          timerInc;

    // Signed offsets from rest; X wins ties for the dominant axis.
    always_comb begin
        dx       = $signed({1'b0, bus.x_pos}) - CENTER_S;
        dy       = $signed({1'b0, bus.y_pos}) - CENTER_S;
        absX     = dx[AXIS_W] ? AXIS_W'(0) - dx : dx;
        absY     = dy[AXIS_W] ? AXIS_W'(0) - dy : dy;
        isCentre = (absX <= DZ_LIM) && (absY <= DZ_LIM);
        if (absX >= absY) begin
            candDir = dx[AXIS_W] ? DIR_LEFT : DIR_RIGHT;
        end else begin
            candDir = dy[AXIS_W] ? DIR_DOWN : DIR_UP;
        end
        case (held_q)
            DIR_RIGHT: release_c = dx[AXIS_W]  || (absX < REL_LIM);
            DIR_LEFT:  release_c = !dx[AXIS_W] || (absX < REL_LIM);
            DIR_UP:    release_c = dy[AXIS_W]  || (absY < REL_LIM);
            default:   release_c = !dy[AXIS_W] || (absY < REL_LIM);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        qcnt_d     = qcnt_q;
        held_d     = held_q;
        dirLevel_d = dirLevel_q;
        timer_d    = timer_q;
        rep_d      = rep_q;
        qualify    = 1'b0;
        emit       = 1'b0;
        emitDir    = held_q;
        qcntInc    = qcnt_q + QW'(1);
        timerInc   = timer_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (bus.sample_valid && !isCentre) begin
                    state_d = QUAL;
                    cand_d  = candDir;
                    qcnt_d  = QW'(1);
                    qualify = (STABLE_CNT <= 1);
                end
            end
            QUAL: begin
                if (bus.sample_valid) begin
                    if (isCentre) begin
                        state_d = IDLE;
                        qcnt_d  = '0;
                    end else if (candDir == cand_q) begin
                        qcnt_d  = qcntInc;
                        qualify = (qcntInc >= QW'(STABLE_CNT));
                    end else begin
                        cand_d  = candDir;
                        qcnt_d  = QW'(1);
                        qualify = (STABLE_CNT <= 1);
                    end
                end
            end
            HELD: begin
                if (bus.sample_valid && release_c) begin
                    state_d    = IDLE;
                    dirLevel_d = 3'd0;
                    qcnt_d     = '0;
                    timer_d    = '0;
                    rep_d      = 1'b0;
                end else if (REPEAT_EN != 0) begin
                    // First repeat waits REPEAT_DLY, later ones REPEAT_PER.
                    timer_d = timerInc;
                    if ((!rep_q && timerInc == TW'(REPEAT_DLY)) ||
                        (rep_q && timerInc == TW'(REPEAT_PER))) begin
                        emit    = 1'b1;
                        emitDir = held_q;
                        timer_d = '0;
                        rep_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (qualify) begin
            state_d    = HELD;
            held_d     = candDir;
            dirLevel_d = {1'b0, candDir} + 3'd1;
            qcnt_d     = '0;
            timer_d    = '0;
            rep_d      = 1'b0;
            emit       = 1'b1;
            emitDir    = candDir;
        end
    end

    // Single-entry buffer: a held move is never overwritten until it is taken.
    always_comb begin
        mvValid_d = mvValid_q;
        mvDir_d   = mvDir_q;
        drop_d    = drop_q;
        if (mvValid_q && bus.move_ready) begin
            mvValid_d = 1'b0;
        end
        if (emit) begin
            if (!mvValid_q || bus.move_ready) begin
                mvValid_d = 1'b1;
                mvDir_d   = emitDir;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
        btnPrev_d  = btnPrev_q;
        btnPress_d = 1'b0;
        if (bus.sample_valid) begin
            btnPrev_d  = bus.btn;
            btnPress_d = bus.btn && !btnPrev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_q     <= 2'd0;
            qcnt_q     <= '0;
            held_q     <= 2'd0;
            dirLevel_q <= 3'd0;
            timer_q    <= '0;
            rep_q      <= 1'b0;
            mvValid_q  <= 1'b0;
            mvDir_q    <= 2'd0;
            drop_q     <= 8'd0;
            btnPrev_q  <= 1'b0;
            btnPress_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            qcnt_q     <= qcnt_d;
            held_q     <= held_d;
            dirLevel_q <= dirLevel_d;
            timer_q    <= timer_d;
            rep_q      <= rep_d;
            mvValid_q  <= mvValid_d;
            mvDir_q    <= mvDir_d;
            drop_q     <= drop_d;
            btnPrev_q  <= btnPrev_d;
            btnPress_q <= btnPress_d;
        end
    end

    assign bus.move_valid = mvValid_q;
    assign bus.move_dir   = mvDir_q;
    assign bus.dir_level  = dirLevel_q;
    assign bus.btn_press  = btnPress_q;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_jstk_move_decoder.sv
// Directed bench: dut0 has the default (no repeat) configuration,
// and dut1 enables a short auto-repeat. Both see the same stimulus.
module tb_jstk_move_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sv;
    logic [9:0] xPos, yPos;
    logic       btn;
    logic       ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int moves0 = 0;
    logic [1:0] lastDir0 = 2'd0;
    logic [1:0] lastDir1 = 2'd0;
    int stamps1[$];
    int base;

    always #5 clk = ~clk;

    jstk_move_decoder_if #(.AXIS_W(10)) if0 ();
    jstk_move_decoder_if #(.AXIS_W(10)) if1 ();

    assign if0.sample_valid = sv;
    assign if0.x_pos        = xPos;
    assign if0.y_pos        = yPos;
    assign if0.btn          = btn;
    assign if0.move_ready   = ready;
    assign if1.sample_valid = sv;
    assign if1.x_pos        = xPos;
    assign if1.y_pos        = yPos;
    assign if1.btn          = btn;
    assign if1.move_ready   = ready;

    jstk_move_decoder #(.STABLE_CNT(4), .REPEAT_EN(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    jstk_move_decoder #(.STABLE_CNT(4), .REPEAT_EN(1), .REPEAT_DLY(100), .REPEAT_PER(20)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // Accepted-move monitors, sampled just before the registers update.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && if0.move_valid && if0.move_ready) begin
            moves0   <= moves0 + 1;
            lastDir0 <= if0.move_dir;
        end
        if (!rst && if1.move_valid && if1.move_ready) begin
            stamps1.push_back(cyc);
            lastDir1 <= if1.move_dir;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input bit b);
        xPos = 10'(x);
        yPos = 10'(y);
        btn  = b;
        sv   = 1'b1;
        @(negedge clk);
        sv   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sv = 1'b0; xPos = 10'd512; yPos = 10'd512; btn = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", if0.move_valid, 0);
        checkOutput("rst_level", if0.dir_level, 0);
        checkOutput("rst_drop",  if0.drop_cnt, 0);
        checkOutput("rst_btn",   if0.btn_press, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: four right samples qualify one move
        base = moves0;
        repeat (3) applyStimulus(900, 512, 0);
        checkOutput("t1_not_early", if0.move_valid, 0);
        applyStimulus(900, 512, 0);
        checkOutput("t1_valid", if0.move_valid, 1);
        checkOutput("t1_dir",   if0.move_dir, 1);
        checkOutput("t1_level", if0.dir_level, 2);
        @(negedge clk);
        checkOutput("t1_taken", if0.move_valid, 0);
        checkOutput("t1_count", moves0 - base, 1);
        applyStimulus(512, 512, 0);
        checkOutput("t1_release", if0.dir_level, 0);

        // T2: candidate change restarts qualification
        base = moves0;
        repeat (3) applyStimulus(900, 512, 0);
        applyStimulus(512, 100, 0);
        repeat (4) applyStimulus(512, 100, 0);
        checkOutput("t2_count", moves0 - base, 1);
        checkOutput("t2_dir",   lastDir0, 2);
        checkOutput("t2_level", if0.dir_level, 3);
        applyStimulus(512, 512, 0);
        checkOutput("t2_release", if0.dir_level, 0);

        // T3: holding emits once; a new push needs a release first
        base = moves0;
        repeat (20) applyStimulus(100, 512, 0);
        checkOutput("t3_hold_count", moves0 - base, 1);
        checkOutput("t3_level", if0.dir_level, 4);
        applyStimulus(512, 512, 0);
        checkOutput("t3_idle", if0.dir_level, 0);
        repeat (4) applyStimulus(100, 512, 0);
        @(negedge clk);
        checkOutput("t3_count", moves0 - base, 2);
        checkOutput("t3_dir",   lastDir0, 3);
        applyStimulus(512, 512, 0);

        // T4: hysteresis on the latched axis
        base = moves0;
        repeat (4) applyStimulus(712, 512, 0);
        checkOutput("t4_level", if0.dir_level, 2);
        applyStimulus(652, 512, 0);
        checkOutput("t4_hyst_hold", if0.dir_level, 2);
        applyStimulus(632, 512, 0);
        checkOutput("t4_hyst_rel", if0.dir_level, 0);
        @(negedge clk);
        checkOutput("t4_count", moves0 - base, 1);

        // T5: full buffer drops the second push and keeps the first
        ready = 1'b0;
        base = moves0;
        repeat (4) applyStimulus(900, 512, 0);
        checkOutput("t5_valid", if0.move_valid, 1);
        checkOutput("t5_dir1",  if0.move_dir, 1);
        applyStimulus(512, 512, 0);
        repeat (4) applyStimulus(512, 900, 0);
        checkOutput("t5_drop",   if0.drop_cnt, 1);
        checkOutput("t5_kept",   if0.move_dir, 1);
        checkOutput("t5_still",  if0.move_valid, 1);
        checkOutput("t5_uplevel", if0.dir_level, 1);
        applyStimulus(512, 512, 0);
        ready = 1'b1;
        @(negedge clk);
        checkOutput("t5_count",   moves0 - base, 1);
        checkOutput("t5_dir_out", lastDir0, 1);
        checkOutput("t5_empty",   if0.move_valid, 0);

        // Button edge pulse
        applyStimulus(512, 512, 1);
        checkOutput("btn_rise", if0.btn_press, 1);
        @(negedge clk);
        checkOutput("btn_width", if0.btn_press, 0);
        applyStimulus(512, 512, 1);
        checkOutput("btn_held", if0.btn_press, 0);
        applyStimulus(512, 512, 0);
        applyStimulus(512, 512, 1);
        checkOutput("btn_again", if0.btn_press, 1);

        // T6: auto-repeat while held up, then reset mid-hold
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stamps1.delete();
        xPos = 10'd512; yPos = 10'd900; btn = 1'b0; sv = 1'b1;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_valid", if1.move_valid, 0);
        checkOutput("t6_rst_level", if1.dir_level, 0);
        checkOutput("t6_rst_drop",  if1.drop_cnt, 0);
        rst = 1'b0;
        sv  = 1'b0;
        @(negedge clk);
        checkOutput("t6_count_ok", 32'(stamps1.size() >= 4), 1);
        checkOutput("t6_dir", lastDir1, 0);
        if (stamps1.size() >= 4) begin
            checkOutput("t6_first_rep", stamps1[1] - stamps1[0], 100);
            checkOutput("t6_per_a",     stamps1[2] - stamps1[1], 20);
            checkOutput("t6_per_b",     stamps1[3] - stamps1[2], 20);
        end
        checkOutput("t6_norep_dut0", if0.drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
